onehot_encoder_seq: RTL and testbench

- Sequential encoder, the inverse of the team's 3-to-8 enable decoder.
- Accepts an 8-bit request vector through a valid/ready handshake and latches it.
- Emits the 3-bit index of every set bit, one per accepted output beat, in priority order.
- Sits between request sources (switches, IRQ lines) and any consumer of a 3-bit select code, e.g. the decoder.

---
 rtl/onehot_encoder_seq.sv | 142 ++++++++++++++
 tb/tb_onehot_encoder_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_encoder_seq.sv
// onehot_encoder_seq: latches a request vector and emits each set bit's index, one beat per cycle, first code the cycle after capture.
// out_ready low holds the current beat stable; defining ONEHOT_STRICT_EN adds err and accepts only one-hot vectors.
module onehot_encoder_seq #(
  parameter int WIDTH     = 8,
  parameter int CODE_W    = 3,
  parameter int PRIO_HIGH = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  d,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_last,
  output logic              busy
`ifdef ONEHOT_STRICT_EN
  ,
  output logic              err
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  pending_q, pending_d;
  logic [WIDTH-1:0]  sel_mask;
  logic [CODE_W-1:0] sel_idx;
  logic              single_bit;
  logic              emitting;
  logic              capture;
  logic              beat;

`ifdef ONEHOT_STRICT_EN
  logic err_q, err_d;
  logic d_onehot;
  assign d_onehot = (d != '0) && ((d & (d - WIDTH'(1))) == '0);
`endif

  // The last hit of the scan wins, so scan direction sets the priority.
  always_comb begin
    sel_idx  = '0;
    sel_mask = '0;
    if (PRIO_HIGH != 0) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (pending_q[i]) begin
          sel_idx  = CODE_W'(i);
          sel_mask = '0;
          sel_mask[i] = 1'b1;
        end
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (pending_q[i]) begin
          sel_idx  = CODE_W'(i);
          sel_mask = '0;
          sel_mask[i] = 1'b1;
        end
      end
    end
  end

  assign single_bit = (pending_q != '0) && ((pending_q & (pending_q - WIDTH'(1))) == '0);
  assign emitting   = (state_q == EMIT);

  // rst gates in_ready so the reset value is visible as soon as rst rises.
  assign in_ready  = (state_q == IDLE) && en && !rst;
  assign out_valid = emitting;
  assign out_code  = emitting ? sel_idx : '0;
  assign out_last  = emitting && single_bit;
  assign busy      = emitting;

  assign capture = in_valid && in_ready;
  assign beat    = out_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
`ifdef ONEHOT_STRICT_EN
    err_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (capture) begin
`ifdef ONEHOT_STRICT_EN
          if (d_onehot) begin
            pending_d = d;
            state_d   = EMIT;
          end else begin
            err_d = 1'b1;
          end
`else
          if (d != '0) begin
            pending_d = d;
            state_d   = EMIT;
          end
`endif
        end
      end
      EMIT: begin
        if (beat) begin
          pending_d = pending_q & ~sel_mask;
          if (single_bit) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

`ifdef ONEHOT_STRICT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_onehot_encoder_seq.sv
// Bench for onehot_encoder_seq: two instances (low and high priority) share stimulus; a queue model gives the expected code stream.
module tb_onehot_encoder_seq;

  localparam int W  = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          in_valid;
  logic          out_ready;
  logic [W-1:0]  d;

  logic          in_ready_l, out_valid_l, out_last_l, busy_l;
  logic [CW-1:0] code_l;
  logic          in_ready_h, out_valid_h, out_last_h, busy_h;
  logic [CW-1:0] code_h;
`ifdef ONEHOT_STRICT_EN
  logic          err_l, err_h;
`endif

  always #5 clk = ~clk;

  onehot_encoder_seq #(.WIDTH(W), .CODE_W(CW), .PRIO_HIGH(0)) dut_l (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready_l),
    .d(d), .out_valid(out_valid_l), .out_ready(out_ready), .out_code(code_l),
    .out_last(out_last_l), .busy(busy_l)
`ifdef ONEHOT_STRICT_EN
    , .err(err_l)
`endif
  );

  onehot_encoder_seq #(.WIDTH(W), .CODE_W(CW), .PRIO_HIGH(1)) dut_h (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready_h),
    .d(d), .out_valid(out_valid_h), .out_ready(out_ready), .out_code(code_h),
    .out_last(out_last_h), .busy(busy_h)
`ifdef ONEHOT_STRICT_EN
    , .err(err_h)
`endif
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   ql[$];
  int   qh[$];
  logic err_exp = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_vec(input logic [W-1:0] v);
    for (int i = 0; i < W; i++)
      if (v[i]) ql.push_back(i);
    for (int i = W - 1; i >= 0; i--)
      if (v[i]) qh.push_back(i);
  endtask

  task automatic model_reset();
    ql.delete();
    qh.delete();
    err_exp = 1'b0;
  endtask

  // Model of one rising edge: pending codes live in queues, in emission order.
  task automatic model_edge();
    bit cap, bt;
    if (rst) begin
      model_reset();
      return;
    end
    cap     = in_valid && en && (ql.size() == 0);
    bt      = (ql.size() != 0) && out_ready;
    err_exp = 1'b0;
    if (bt) begin
      void'(ql.pop_front());
      void'(qh.pop_front());
    end
    if (cap) begin
`ifdef ONEHOT_STRICT_EN
      if ($countones(d) != 1) err_exp = 1'b1;
      else push_vec(d);
`else
      if (d != '0) push_vec(d);
`endif
    end
  endtask

  task automatic cmp_side(input string tag, input logic ir, input logic ov, input logic [CW-1:0] oc,
                          input logic ol, input logic bz, input int n, input int qf);
    check({tag, ".in_ready"},  32'(ir), 32'(en && !rst && n == 0));
    check({tag, ".out_valid"}, 32'(ov), 32'(n != 0));
    check({tag, ".out_code"},  32'(oc), (n != 0) ? 32'(qf) : 32'd0);
    check({tag, ".out_last"},  32'(ol), 32'(n == 1));
    check({tag, ".busy"},      32'(bz), 32'(n != 0));
  endtask

  task automatic compare_all();
    cmp_side("lo", in_ready_l, out_valid_l, code_l, out_last_l, busy_l,
             ql.size(), (ql.size() != 0) ? ql[0] : 0);
    cmp_side("hi", in_ready_h, out_valid_h, code_h, out_last_h, busy_h,
             qh.size(), (qh.size() != 0) ? qh[0] : 0);
`ifdef ONEHOT_STRICT_EN
    check("lo.err", 32'(err_l), 32'(err_exp));
    check("hi.err", 32'(err_h), 32'(err_exp));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1; d = '0;
    #2;
    compare_all();
    check("rst.in_ready", 32'(in_ready_l), 32'd0);
    check("rst.out_valid", 32'(out_valid_l), 32'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    compare_all();
    check("rel.in_ready", 32'(in_ready_l), 32'd1);

`ifndef ONEHOT_STRICT_EN
    // Basic: 0010_0100 -> 2 then 5
    d = 8'h24; in_valid = 1'b1; step(); in_valid = 1'b0;
    check("basic.code0", 32'(code_l), 32'd2);
    check("basic.last0", 32'(out_last_l), 32'd0);
    step();
    check("basic.code1", 32'(code_l), 32'd5);
    check("basic.last1", 32'(out_last_l), 32'd1);
    step();
    check("basic.in_ready", 32'(in_ready_l), 32'd1);
    check("basic.idle", 32'(out_valid_l), 32'd0);

    // Backpressure: 0x81 held for 4 cycles
    d = 8'h81; in_valid = 1'b1; out_ready = 1'b0; step(); in_valid = 1'b0;
    repeat (4) begin
      step();
      check("bp.hold_code", 32'(code_l), 32'd0);
      check("bp.hold_valid", 32'(out_valid_l), 32'd1);
    end
    out_ready = 1'b1; step();
    check("bp.code7", 32'(code_l), 32'd7);
    check("bp.last7", 32'(out_last_l), 32'd1);
    step();
    check("bp.done", 32'(out_valid_l), 32'd0);

    // Zero vector accepted and dropped; en=0 blocks capture
    d = 8'h00; in_valid = 1'b1; step();
    check("zero.valid", 32'(out_valid_l), 32'd0);
    check("zero.in_ready", 32'(in_ready_l), 32'd1);
    en = 1'b0; d = 8'h10; step();
    check("en0.in_ready", 32'(in_ready_l), 32'd0);
    check("en0.valid", 32'(out_valid_l), 32'd0);
    in_valid = 1'b0; en = 1'b1; step();
    check("en0.nocap", 32'(out_valid_l), 32'd0);

    // Priority: 1000_0011
    d = 8'h83; in_valid = 1'b1; step(); in_valid = 1'b0;
    check("prio.h0", 32'(code_h), 32'd7);
    check("prio.l0", 32'(code_l), 32'd0);
    step();
    check("prio.h1", 32'(code_h), 32'd1);
    step();
    check("prio.h2", 32'(code_h), 32'd0);
    check("prio.hlast", 32'(out_last_h), 32'd1);
    check("prio.l2", 32'(code_l), 32'd7);
    step();

    // Reset in the middle of 0xFF after three beats
    d = 8'hFF; in_valid = 1'b1; step(); in_valid = 1'b0;
    step(); step(); step();
    check("mid.code3", 32'(code_l), 32'd3);
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("mid.valid", 32'(out_valid_l), 32'd0);
    check("mid.in_ready", 32'(in_ready_l), 32'd0);
    step();
    rst = 1'b0;
    #1;
    compare_all();
    check("mid.rel_ready", 32'(in_ready_l), 32'd1);
    d = 8'h01; in_valid = 1'b1; step(); in_valid = 1'b0;
    check("mid.code", 32'(code_l), 32'd0);
    check("mid.last", 32'(out_last_l), 32'd1);
    step();
    check("mid.idle", 32'(out_valid_l), 32'd0);
`else
    // Strict: non-one-hot dropped with an err pulse, one-hot gives one beat
    d = 8'h06; in_valid = 1'b1; step(); in_valid = 1'b0;
    check("strict.err", 32'(err_l), 32'd1);
    check("strict.novalid", 32'(out_valid_l), 32'd0);
    step();
    check("strict.err_clr", 32'(err_l), 32'd0);
    d = 8'h00; in_valid = 1'b1; step(); in_valid = 1'b0;
    check("strict.zero_err", 32'(err_l), 32'd1);
    d = 8'h40; in_valid = 1'b1; step(); in_valid = 1'b0;
    check("strict.code", 32'(code_l), 32'd6);
    check("strict.last", 32'(out_last_l), 32'd1);
    check("strict.noerr", 32'(err_l), 32'd0);
    step();
    check("strict.idle", 32'(out_valid_l), 32'd0);
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
